// File: rtl/uart_rx_frame_deserializer.sv
// UART receive front end: 2-flop input synchronizer, oversampled start-bit
// qualification, 8 data bits + parity shifted in LSB first, stop-bit check,
// and a single-entry holding register with valid/ack handshake and sticky overrun.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s low on a baud tick
// S_START  | start bit seen, confirm low at mid-bit (glitch filter)
// S_DATA   | sampling data bits 0..7 at bit centres
// S_PARITY | sampling the parity bit into frame bit 8
// S_STOP   | sampling the stop bit, then completing the frame
module uart_rx_frame_deserializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_baud_tick,
    input  logic       i_rx,
    output logic [8:0] o_frame_out,
    output logic       o_frame_valid,
    input  logic       i_frame_ack,
    output logic       o_framing_error,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_nxt;
    logic [8:0]        r_shift;
    logic [8:0]        w_shift_nxt;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic              w_complete;
    logic              w_load;
    logic              w_set_ovr;
    logic              w_ack_ok;

    logic [8:0]        r_frame;
    logic              r_frame_valid;
    logic              r_framing_error;
    logic              r_overrun;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State, bit-phase counter, bit counter and shift register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Next-state logic; everything holds between baud ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        if (i_baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == HALF_LAST) begin
                        w_tick_nxt = '0;
                        if (r_rx_s) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_bit_nxt   = '0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_tick_nxt             = '0;
                        w_shift_nxt[r_bit_cnt] = r_rx_s;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_tick_nxt     = '0;
                        w_shift_nxt[8] = r_rx_s;
                        w_state_nxt    = S_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_tick_nxt  = '0;
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                end
            endcase
        end
    end

    // A completing frame loads only if the holder is empty or being emptied now.
    assign w_ack_ok  = i_frame_ack && r_frame_valid;
    assign w_load    = w_complete && (!r_frame_valid || i_frame_ack);
    assign w_set_ovr = w_complete && r_frame_valid && !i_frame_ack;

    // Holding register, handshake and sticky overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame         <= '0;
            r_frame_valid   <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            if (w_load) begin
                r_frame         <= r_shift;
                r_framing_error <= !r_rx_s;
                r_frame_valid   <= 1'b1;
            end else if (w_ack_ok) begin
                r_frame_valid <= 1'b0;
            end
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end else if (i_frame_ack) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_frame_out     = r_frame;
    assign o_frame_valid   = r_frame_valid;
    assign o_framing_error = r_framing_error;
    assign o_overrun       = r_overrun;
    assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Directed bench for the UART receive deserializer at OVERSAMPLE=16 with a
// baud tick every 4 clocks (one bit = 64 clocks).
module tb_uart_rx_frame_deserializer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_baud_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_frame_ack = 1'b0;
    logic [8:0] o_frame_out;
    logic       o_frame_valid;
    logic       o_framing_error;
    logic       o_overrun;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int tcnt = 0;

    uart_rx_frame_deserializer #(.OVERSAMPLE(16)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_baud_tick     (i_baud_tick),
        .i_rx            (i_rx),
        .o_frame_out     (o_frame_out),
        .o_frame_valid   (o_frame_valid),
        .i_frame_ack     (i_frame_ack),
        .o_framing_error (o_framing_error),
        .o_overrun       (o_overrun),
        .o_busy          (o_busy)
    );

    initial forever #5 i_clk = ~i_clk;

    // Baud tick: high for one clock out of every four, changed on the falling edge.
    always @(negedge i_clk) begin
        tcnt        = (tcnt + 1) % 4;
        i_baud_tick = (tcnt == 0);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    // Leaves us just after a falling edge whose following rising edge is a tick.
    task automatic align_tick();
        @(negedge i_clk);
        #1;
        while (!i_baud_tick) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        wait_clk(n);
    endtask

    // Full 11-bit frame; optionally pulse ack exactly in the stop-sample cycle
    // (36 clocks into the stop bit given the tick alignment above).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic ack_at_stop);
        align_tick();
        i_rx = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            wait_clk(64);
        end
        i_rx = p;
        wait_clk(64);
        i_rx = s;
        if (ack_at_stop) begin
            wait_clk(36);
            i_frame_ack = 1'b1;
            wait_clk(1);
            i_frame_ack = 1'b0;
            wait_clk(27);
        end else begin
            wait_clk(64);
        end
        i_rx = 1'b1;
    endtask

    task automatic pulse_ack();
        i_frame_ack = 1'b1;
        wait_clk(1);
        i_frame_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_frame_out"}, 16'(o_frame_out), 16'h000);
        check({tag, "_valid"},     16'(o_frame_valid), 16'h0);
        check({tag, "_ferr"},      16'(o_framing_error), 16'h0);
        check({tag, "_overrun"},   16'(o_overrun), 16'h0);
        check({tag, "_busy"},      16'(o_busy), 16'h0);
    endtask

    initial begin
        i_rst = 1'b1;
        wait_clk(5);
        check_reset_vals("reset");
        i_rst = 1'b0;
        idle(100);

        // 0xA5, parity 0, stop 1
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_frame", 16'(o_frame_out), 16'h0A5);
        check("a5_valid", 16'(o_frame_valid), 16'h1);
        check("a5_ferr",  16'(o_framing_error), 16'h0);
        check("a5_ovr",   16'(o_overrun), 16'h0);
        check("a5_busy",  16'(o_busy), 16'h0);
        pulse_ack();
        check("a5_ack_valid", 16'(o_frame_valid), 16'h0);
        check("a5_ack_hold",  16'(o_frame_out), 16'h0A5);

        // 0x01 with parity 1: even parity over all nine bits holds
        idle(100);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        check("p1_frame",  16'(o_frame_out), 16'h101);
        check("p1_parerr", 16'(^o_frame_out), 16'h0);
        check("p1_valid",  16'(o_frame_valid), 16'h1);
        pulse_ack();
        check("p1_ack_valid", 16'(o_frame_valid), 16'h0);
        wait_clk(3);
        check("idle_ack_ignored", 16'(o_frame_valid), 16'h0);

        // 4-tick low glitch on the idle line
        idle(100);
        align_tick();
        i_rx = 1'b0;
        wait_clk(16);
        i_rx = 1'b1;
        wait_clk(4);
        check("glitch_busy_hi", 16'(o_busy), 16'h1);
        wait_clk(28);
        check("glitch_busy_lo", 16'(o_busy), 16'h0);
        check("glitch_valid",   16'(o_frame_valid), 16'h0);

        // 0x3C with stop bit 0
        idle(100);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("ferr_frame", 16'(o_frame_out), 16'h03C);
        check("ferr_flag",  16'(o_framing_error), 16'h1);
        check("ferr_valid", 16'(o_frame_valid), 16'h1);
        pulse_ack();
        check("ferr_ack_valid", 16'(o_frame_valid), 16'h0);

        // Back-to-back 0x11 then 0x22, no ack: second is dropped
        idle(200);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check("ovr_frame", 16'(o_frame_out), 16'h011);
        check("ovr_flag",  16'(o_overrun), 16'h1);
        check("ovr_valid", 16'(o_frame_valid), 16'h1);
        check("ovr_ferr",  16'(o_framing_error), 16'h0);
        pulse_ack();
        check("ovr_ack_valid", 16'(o_frame_valid), 16'h0);
        check("ovr_ack_flag",  16'(o_overrun), 16'h0);

        // Ack coincides with the completion of the next frame
        idle(100);
        send_frame(8'h33, 1'b1, 1'b1, 1'b0);
        check("same_first", 16'(o_frame_out), 16'h133);
        idle(100);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check("same_frame", 16'(o_frame_out), 16'h022);
        check("same_valid", 16'(o_frame_valid), 16'h1);
        check("same_ovr",   16'(o_overrun), 16'h0);

        // Reset during the data bits of 0xFF while 0x022 is still held
        idle(100);
        align_tick();
        i_rx = 1'b0;
        wait_clk(64);
        i_rx = 1'b1;
        wait_clk(150);
        check("midrst_busy", 16'(o_busy), 16'h1);
        i_rst = 1'b1;
        wait_clk(1);
        check_reset_vals("midrst");
        i_rst = 1'b0;
        idle(300);
        check("midrst_still_idle", 16'(o_busy), 16'h0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("post_frame", 16'(o_frame_out), 16'h05A);
        check("post_valid", 16'(o_frame_valid), 16'h1);
        check("post_ferr",  16'(o_framing_error), 16'h0);
        check("post_ovr",   16'(o_overrun), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
